// File: rtl/sample_player.sv
// sample_player: multi-channel sample playback engine.
// Each channel streams signed PCM from one shared synchronous sample ROM at its
// own programmable rate. A round-robin arbiter shares the ROM port, and the
// channel samples are mixed with saturation into one signed 16-bit word.
//
// Ports:
//   clk, reset_n       clock (rising edge) and asynchronous active-low reset
//   pause              freezes playback state, arbiter and audio_out
//   trigger[ch]        rising edge starts/restarts a channel
//   stop[ch]           level stop, beats trigger
//   loop[ch]           loop enable, looked at when a channel runs out of samples
//   start_addr/length  per-channel ROM base and sample count (ADDR_WIDTH each)
//   divider            per-channel period, one sample lasts divider+1 clk
//   rom_addr/rom_data  shared ROM port, data valid one clk after the address
//   playing[ch]        channel is not idle
//   audio_out          registered saturated mix
module sample_player #(
    parameter int CHANNELS   = 2,
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8,
    parameter int DIV_WIDTH  = 10
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           pause,
    input  logic [CHANNELS-1:0]            trigger,
    input  logic [CHANNELS-1:0]            stop,
    input  logic [CHANNELS-1:0]            loop,
    input  logic [CHANNELS*ADDR_WIDTH-1:0] start_addr,
    input  logic [CHANNELS*ADDR_WIDTH-1:0] length,
    input  logic [CHANNELS*DIV_WIDTH-1:0]  divider,
    output logic [ADDR_WIDTH-1:0]          rom_addr,
    input  logic [DATA_WIDTH-1:0]          rom_data,
    output logic [CHANNELS-1:0]            playing,
    output logic [15:0]                    audio_out
);

    localparam int CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int SUM_W = 16 + $clog2(CHANNELS) + 1;
    localparam int SHIFT = 16 - DATA_WIDTH;

    localparam logic [CH_W-1:0]       CH_ONE   = CH_W'(1'b1);
    localparam logic [CH_W-1:0]       CH_LAST  = CH_W'(CHANNELS - 1);
    localparam logic [DIV_WIDTH-1:0]  DIV_ONE  = DIV_WIDTH'(1'b1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1'b1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_REQ  = 2'd2,
        ST_READ = 2'd3
    } state_t;

    state_t                state_q  [CHANNELS];
    state_t                state_d  [CHANNELS];
    logic [ADDR_WIDTH-1:0] ptr_q    [CHANNELS];
    logic [ADDR_WIDTH-1:0] ptr_d    [CHANNELS];
    logic [DIV_WIDTH-1:0]  cnt_q    [CHANNELS];
    logic [DIV_WIDTH-1:0]  cnt_d    [CHANNELS];
    logic [DATA_WIDTH-1:0] sample_q [CHANNELS];
    logic [DATA_WIDTH-1:0] sample_d [CHANNELS];
    logic [CHANNELS-1:0]   trig_last_q, trig_last_d;
    logic [CH_W-1:0]       rr_q, rr_d;
    logic [ADDR_WIDTH-1:0] rom_addr_q, rom_addr_d;
    // Two-stage grant tag: stage 1 while the ROM registers the address,
    // stage 2 when rom_data belongs to that grant.
    logic                  tag1_vld_q, tag1_vld_d, tag2_vld_q, tag2_vld_d;
    logic [CH_W-1:0]       tag1_ch_q, tag1_ch_d, tag2_ch_q, tag2_ch_d;
    logic [CHANNELS-1:0]   playing_q, playing_d;
    logic [15:0]           audio_q, audio_d;

    logic [CHANNELS-1:0]   trig_edge_s, req_s, kill_s;
    logic                  gnt_vld_s, lo_vld_s, hi_vld_s;
    logic [CH_W-1:0]       gnt_ch_s, lo_ch_s, hi_ch_s;
    logic [SUM_W-1:0]      sum_s;

    assign trig_edge_s = trigger & ~trig_last_q;

    // Per-channel request and in-flight-fetch kill qualifiers.
    always_comb begin
        req_s  = '0;
        kill_s = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            // A channel being stopped or restarted this cycle must not be granted.
            req_s[i]  = !pause && (state_q[i] == ST_REQ) && !stop[i] && !trig_edge_s[i];
            kill_s[i] = !pause && (stop[i] || trig_edge_s[i]);
        end
    end

    // Round-robin arbiter: lowest requester at/after rr_q, else lowest overall.
    always_comb begin
        lo_vld_s = 1'b0;
        lo_ch_s  = '0;
        hi_vld_s = 1'b0;
        hi_ch_s  = '0;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (req_s[i]) begin
                lo_vld_s = 1'b1;
                lo_ch_s  = CH_W'(i);
            end else begin
                lo_vld_s = lo_vld_s;
            end
            if (req_s[i] && (CH_W'(i) >= rr_q)) begin
                hi_vld_s = 1'b1;
                hi_ch_s  = CH_W'(i);
            end else begin
                hi_vld_s = hi_vld_s;
            end
        end
        gnt_vld_s = lo_vld_s;
        gnt_ch_s  = hi_vld_s ? hi_ch_s : lo_ch_s;
        if (!gnt_vld_s) begin
            rr_d = rr_q;
        end else if (gnt_ch_s == CH_LAST) begin
            rr_d = '0;
        end else begin
            rr_d = gnt_ch_s + CH_ONE;
        end
    end

    // Channel FSMs, rate counters, ROM address and grant tag pipeline.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        sample_d    = sample_q;
        trig_last_d = trig_last_q;
        rom_addr_d  = rom_addr_q;
        tag1_vld_d  = gnt_vld_s;
        tag1_ch_d   = gnt_ch_s;
        tag2_vld_d  = tag1_vld_q;
        tag2_ch_d   = tag1_ch_q;
        for (int i = 0; i < CHANNELS; i++) begin
            trig_last_d[i] = pause ? trig_last_q[i] : trigger[i];
            // Data already requested for a stopped/restarted channel is dropped.
            if (tag1_vld_q && (tag1_ch_q == CH_W'(i)) && kill_s[i]) begin
                tag2_vld_d = 1'b0;
            end else begin
                tag2_vld_d = tag2_vld_d;
            end
            if (gnt_vld_s && (gnt_ch_s == CH_W'(i))) begin
                rom_addr_d = start_addr[i*ADDR_WIDTH +: ADDR_WIDTH] + ptr_q[i];
            end else begin
                rom_addr_d = rom_addr_d;
            end

            if (!pause && stop[i]) begin
                state_d[i]  = ST_IDLE;
                sample_d[i] = '0;
            end else if (!pause && trig_edge_s[i]) begin
                if ((state_q[i] != ST_IDLE) || (length[i*ADDR_WIDTH +: ADDR_WIDTH] != '0)) begin
                    ptr_d[i]   = '0;
                    cnt_d[i]   = divider[i*DIV_WIDTH +: DIV_WIDTH];
                    state_d[i] = ST_REQ;
                    if (state_q[i] == ST_IDLE) begin
                        sample_d[i] = '0;
                    end else begin
                        sample_d[i] = sample_q[i];
                    end
                end else begin
                    state_d[i] = ST_IDLE;
                end
            end else begin
                if (!pause && (state_q[i] != ST_IDLE)) begin
                    cnt_d[i] = (cnt_q[i] == '0) ? divider[i*DIV_WIDTH +: DIV_WIDTH]
                                                : cnt_q[i] - DIV_ONE;
                end else begin
                    cnt_d[i] = cnt_q[i];
                end
                case (state_q[i])
                    ST_WAIT: begin
                        // Tick = counter at zero; ticks outside WAIT are lost.
                        if (!pause && (cnt_q[i] == '0)) begin
                            if (ptr_q[i] < length[i*ADDR_WIDTH +: ADDR_WIDTH]) begin
                                state_d[i] = ST_REQ;
                            end else if (loop[i]) begin
                                ptr_d[i]   = '0;
                                state_d[i] = ST_REQ;
                            end else begin
                                sample_d[i] = '0;
                                state_d[i]  = ST_IDLE;
                            end
                        end else begin
                            state_d[i] = ST_WAIT;
                        end
                    end
                    ST_REQ: begin
                        if (gnt_vld_s && (gnt_ch_s == CH_W'(i))) begin
                            state_d[i] = ST_READ;
                        end else begin
                            state_d[i] = ST_REQ;
                        end
                    end
                    ST_READ: begin
                        // Capture completes even while paused.
                        if (tag2_vld_q && (tag2_ch_q == CH_W'(i))) begin
                            sample_d[i] = rom_data;
                            ptr_d[i]    = ptr_q[i] + ADDR_ONE;
                            state_d[i]  = ST_WAIT;
                        end else begin
                            state_d[i] = ST_READ;
                        end
                    end
                    default: begin
                        state_d[i] = state_q[i];
                    end
                endcase
            end
            playing_d[i] = (state_d[i] != ST_IDLE);
        end
    end

    // Sign-extend, scale to 16-bit full scale, sum and saturate.
    always_comb begin
        sum_s = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            sum_s = sum_s + ({{(SUM_W-DATA_WIDTH){sample_q[i][DATA_WIDTH-1]}}, sample_q[i]} << SHIFT);
        end
        if (pause) begin
            audio_d = audio_q;
        end else if ((sum_s[SUM_W-1:15] == '0) || (sum_s[SUM_W-1:15] == '1)) begin
            audio_d = sum_s[15:0];
        end else if (sum_s[SUM_W-1]) begin
            audio_d = 16'h8000;
        end else begin
            audio_d = 16'h7FFF;
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < CHANNELS; i++) begin
                state_q[i]  <= ST_IDLE;
                ptr_q[i]    <= '0;
                cnt_q[i]    <= '0;
                sample_q[i] <= '0;
            end
            trig_last_q <= '0;
            rr_q        <= '0;
            rom_addr_q  <= '0;
            tag1_vld_q  <= 1'b0;
            tag1_ch_q   <= '0;
            tag2_vld_q  <= 1'b0;
            tag2_ch_q   <= '0;
            playing_q   <= '0;
            audio_q     <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                state_q[i]  <= state_d[i];
                ptr_q[i]    <= ptr_d[i];
                cnt_q[i]    <= cnt_d[i];
                sample_q[i] <= sample_d[i];
            end
            trig_last_q <= trig_last_d;
            rr_q        <= rr_d;
            rom_addr_q  <= rom_addr_d;
            tag1_vld_q  <= tag1_vld_d;
            tag1_ch_q   <= tag1_ch_d;
            tag2_vld_q  <= tag2_vld_d;
            tag2_ch_q   <= tag2_ch_d;
            playing_q   <= playing_d;
            audio_q     <= audio_d;
        end
    end

    assign rom_addr  = rom_addr_q;
    assign playing   = playing_q;
    assign audio_out = audio_q;

endmodule

// File: tb/tb_sample_player.sv
// Self-checking bench for sample_player (2 channels, 8-bit samples).
// Directed scenarios plus randomized one-shot playbacks compared against a
// reference built from the playback rules (expected audio value sequence and
// playback duration).
module tb_sample_player;

    logic        clk;
    logic        reset_n;
    logic        pause;
    logic [1:0]  trigger;
    logic [1:0]  stop;
    logic [1:0]  loop_en;
    logic [31:0] start_addr;
    logic [31:0] length;
    logic [19:0] divider;
    logic [15:0] rom_addr;
    logic [7:0]  rom_data;
    logic [1:0]  playing;
    logic [15:0] audio_out;

    logic [7:0]  rom [0:65535];
    int checks;
    int errors;

    sample_player #(
        .CHANNELS(2), .ADDR_WIDTH(16), .DATA_WIDTH(8), .DIV_WIDTH(10)
    ) dut (
        .clk(clk), .reset_n(reset_n), .pause(pause), .trigger(trigger),
        .stop(stop), .loop(loop_en), .start_addr(start_addr), .length(length),
        .divider(divider), .rom_addr(rom_addr), .rom_data(rom_data),
        .playing(playing), .audio_out(audio_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous ROM model.
    always @(posedge clk) rom_data <= rom[rom_addr];

    task automatic chk(input string tag, input logic signed [31:0] obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick_n(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic int aud(input logic [7:0] b);
        return int'($signed(b)) * 256;
    endfunction

    function automatic int clamp16(input int s);
        if (s > 32767) return 32767;
        if (s < -32768) return -32768;
        return s;
    endfunction

    task automatic cfg(input int ch, input int st, input int len, input int dv, input bit lp);
        start_addr[ch*16 +: 16] = st[15:0];
        length[ch*16 +: 16]     = len[15:0];
        divider[ch*10 +: 10]    = dv[9:0];
        loop_en[ch]             = lp;
    endtask

    task automatic pulse_trig(input int ch);
        trigger[ch] = 1'b1;
        tick_n(1);
        trigger[ch] = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int w;
        w = 0;
        while ((playing != 2'b00) && (w < 200)) begin
            tick_n(1);
            w++;
        end
        chk(tag, playing, 0);
        tick_n(1);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int exp;
        int expq[$];
        int obsq[$];
        int ch, st, len, dv, pc, a, n;

        checks = 0;
        errors = 0;
        for (int i = 0; i < 65536; i++) rom[i] = 8'($urandom);
        rom[16'h100] = 8'd10; rom[16'h101] = 8'd20;
        rom[16'h102] = 8'd30; rom[16'h103] = 8'd40;
        rom[16'h200] = 8'h7F; rom[16'h201] = 8'h80;

        reset_n = 1'b0; pause = 1'b0; trigger = 2'b00; stop = 2'b00;
        loop_en = 2'b00; start_addr = '0; length = '0; divider = '0;
        tick_n(3);
        chk("reset_audio", $signed(audio_out), 0);
        chk("reset_addr", rom_addr, 0);
        chk("reset_playing", playing, 0);
        reset_n = 1'b1;
        tick_n(2);

        // One-shot: 10,20,30,40 at divider 3, first sample audible 4 clk after trigger.
        cfg(0, 'h100, 4, 3, 1'b0);
        pulse_trig(0);
        chk("oneshot_playing", playing[0], 1);
        for (int k = 1; k <= 16; k++) begin
            tick_n(1);
            if (k == 1) chk("oneshot_addr", rom_addr, 'h100);
            exp = (k < 4) ? 0 : aud(rom[16'h100 + (k - 4) / 4]);
            chk($sformatf("oneshot_k%0d", k), $signed(audio_out), exp);
        end
        wait_idle("oneshot_end");
        chk("oneshot_silent", $signed(audio_out), 0);

        // Looping: repeats with no gap; clearing loop ends after the current pass.
        cfg(0, 'h100, 4, 3, 1'b1);
        pulse_trig(0);
        for (int k = 1; k <= 48; k++) begin
            tick_n(1);
            exp = (k < 4) ? 0 : aud(rom[16'h100 + ((k - 4) / 4) % 4]);
            chk($sformatf("loop_k%0d", k), $signed(audio_out), exp);
            if (k == 40) loop_en[0] = 1'b0;
        end
        wait_idle("loop_end");
        chk("loop_silent", $signed(audio_out), 0);

        // Two channels: 127+127 saturates high, -128-128 saturates low.
        cfg(0, 'h200, 2, 7, 1'b0);
        cfg(1, 'h200, 2, 7, 1'b0);
        trigger = 2'b11;
        tick_n(1);
        trigger = 2'b00;
        tick_n(4);
        chk("sat_one_ch", $signed(audio_out), aud(8'h7F));
        tick_n(1);
        chk("sat_hi", $signed(audio_out), clamp16(2 * aud(8'h7F)));
        tick_n(3);
        chk("sat_hi_hold", $signed(audio_out), clamp16(2 * aud(8'h7F)));
        tick_n(4);
        chk("sat_mixed", $signed(audio_out), clamp16(aud(8'h80) + aud(8'h7F)));
        tick_n(1);
        chk("sat_lo", $signed(audio_out), clamp16(2 * aud(8'h80)));
        tick_n(2);
        chk("sat_lo_hold", $signed(audio_out), clamp16(2 * aud(8'h80)));
        wait_idle("sat_end");

        // Stop and trigger together while a fetch is in flight.
        cfg(0, 'h100, 4, 3, 1'b0);
        pulse_trig(0);
        tick_n(5);
        chk("stop_pre_audio", $signed(audio_out), aud(8'd10));
        trigger[0] = 1'b1;
        stop[0] = 1'b1;
        tick_n(1);
        trigger[0] = 1'b0;
        stop[0] = 1'b0;
        chk("stop_playing", playing[0], 0);
        for (int k = 0; k < 4; k++) begin
            tick_n(1);
            chk("stop_audio", $signed(audio_out), 0);
            chk("stop_stays_idle", playing[0], 0);
        end

        // Zero length: trigger ignored.
        cfg(0, 'h100, 0, 3, 1'b0);
        pulse_trig(0);
        for (int k = 0; k < 4; k++) begin
            chk("len0_playing", playing[0], 0);
            tick_n(1);
        end

        // Pause for 20 clk with a fetch in flight.
        cfg(0, 'h100, 4, 3, 1'b0);
        pulse_trig(0);
        tick_n(5);
        chk("pause_pre_addr", rom_addr, 'h101);
        chk("pause_pre_audio", $signed(audio_out), aud(8'd10));
        pause = 1'b1;
        for (int k = 6; k <= 25; k++) begin
            tick_n(1);
            chk("pause_audio", $signed(audio_out), aud(8'd10));
            chk("pause_addr", rom_addr, 'h101);
        end
        pause = 1'b0;
        for (int k = 26; k <= 36; k++) begin
            tick_n(1);
            exp = (k < 32) ? aud(8'd20) : (k < 36) ? aud(8'd30) : aud(8'd40);
            chk($sformatf("resume_k%0d", k), $signed(audio_out), exp);
            if (k == 29) chk("resume_addr", rom_addr, 'h102);
        end
        wait_idle("pause_end");

        // Asynchronous reset between clock edges mid-playback.
        pulse_trig(0);
        tick_n(6);
        chk("rst_pre_audio", $signed(audio_out), aud(8'd10));
        #3;
        reset_n = 1'b0;
        #1;
        chk("rst_async_audio", $signed(audio_out), 0);
        chk("rst_async_addr", rom_addr, 0);
        chk("rst_async_playing", playing, 0);
        tick_n(1);
        reset_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick_n(1);
            chk("rst_stays_idle", playing, 0);
            chk("rst_audio_zero", $signed(audio_out), 0);
        end
        pulse_trig(0);
        chk("rst_retrigger", playing[0], 1);
        wait_idle("rst_end");

        // Randomized one-shots against the rule-based reference.
        for (int r = 0; r < 6; r++) begin
            ch  = $urandom_range(0, 1);
            st  = $urandom_range(0, 65535);
            len = $urandom_range(1, 6);
            dv  = $urandom_range(4, 12);
            cfg(ch, st, len, dv, 1'b0);
            expq = {};
            expq.push_back(0);
            for (int j = 0; j < len; j++) begin
                a = aud(rom[(st + j) & 16'hFFFF]);
                if (a != expq[$]) expq.push_back(a);
            end
            if (expq[$] != 0) expq.push_back(0);
            obsq = {};
            obsq.push_back(0);
            pc = 0;
            pulse_trig(ch);
            repeat (200) begin
                a = int'($signed(audio_out));
                if (a != obsq[$]) obsq.push_back(a);
                if (playing[ch]) pc++;
                tick_n(1);
            end
            chk($sformatf("rnd%0d_count", r), obsq.size(), expq.size());
            n = (obsq.size() < expq.size()) ? obsq.size() : expq.size();
            for (int j = 0; j < n; j++) begin
                chk($sformatf("rnd%0d_val%0d", r, j), obsq[j], expq[j]);
            end
            chk($sformatf("rnd%0d_duration", r), pc, (dv + 1) * len);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sample_player.md
# sample_player

Multi-channel sample playback engine for the discrete-audio replacement path. It is the parametrised successor of the single-channel boom-sample player. Each channel streams signed PCM from a shared synchronous sample ROM at its own programmable rate, with optional looping, retrigger and stop. A round-robin arbiter time-multiplexes the single ROM port, and the channel outputs are mixed with saturation into one signed 16-bit word for the top-level audio mixer.

## Interface
- CHANNELS, 2: number of independent playback channels (1–8).
- ADDR_WIDTH, 16: sample ROM address width.
- DATA_WIDTH, 8: sample width, signed two's complement (1–16).
- DIV_WIDTH, 10: per-channel sample-period divider width.

- clk  in  1  system clock; all state on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- pause  in  1  freezes all playback state while high.
- trigger  in  CHANNELS  per-channel start; acts on rising edge.
- stop  in  CHANNELS  per-channel level stop.
- loop  in  CHANNELS  per-channel loop enable, sampled at end of sample.
- start_addr  in  CHANNELS*ADDR_WIDTH  per-channel ROM base, channel i at [i*ADDR_WIDTH +: ADDR_WIDTH].
- length  in  CHANNELS*ADDR_WIDTH  per-channel sample count.
- divider  in  CHANNELS*DIV_WIDTH  per-channel period; one sample lasts divider+1 clk.
- rom_addr  out  ADDR_WIDTH  registered ROM address.
- rom_data  in  DATA_WIDTH  ROM read data, valid one clk after rom_addr changes.
- playing  out  CHANNELS  high while a channel is not IDLE.
- audio_out  out  16  signed saturated mix, registered.

## Operation
- Per-channel state: FSM (IDLE, WAIT, REQ, READ), ptr (ADDR_WIDTH), cnt (DIV_WIDTH), sample (DATA_WIDTH), trig_last.
- IDLE, trigger rising edge, length≠0: ptr←0, cnt←divider, sample←0, go to REQ so the first fetch is immediate. With length=0 the trigger is ignored.
- Trigger rising edge in any non-IDLE state restarts the channel: ptr←0, cnt←divider, go to REQ. A fetch already in flight for that channel is discarded.
- stop high: go to IDLE with sample←0 regardless of state. Stop beats trigger in the same cycle, and any in-flight data is discarded.
- cnt free-runs down while non-IDLE and reloads divider after reaching 0. A zero crossing is a tick.
- WAIT, on tick:
  - If ptr<length, go to REQ.
  - If ptr==length and loop=1, ptr←0 and go to REQ.
  - If ptr==length and loop=0, sample←0 and go to IDLE.
- Ticks arriving in REQ or READ are dropped. This is an overrun; software must keep divider ≥ CHANNELS+2.
- Arbiter: among channels in REQ, grant the lowest index at or after the round-robin pointer. At most one grant per clk.
  - On a grant: rom_addr←start_addr+ptr (modulo 2^ADDR_WIDTH), the channel goes to READ, and the pointer moves to granted+1 mod CHANNELS.
- READ: capture rom_data into sample two edges after the grant edge, ptr←ptr+1, go to WAIT. A grant/tag pipeline allows back-to-back grants.
- Mix: each sample is sign-extended and shifted left by 16-DATA_WIDTH. The values are summed in a width of 16+ceil(log2 CHANNELS)+1 and clamped to [-32768, 32767].
- pause high: cnt, FSMs, trig_last and the arbiter hold, and no new grants occur. A READ already granted still captures its data. audio_out holds its value.

## Timing
- Reset (asynchronous assert, synchronous-safe release) sets every channel to IDLE, ptr=0, cnt=0, sample=0, trig_last=0, the arbiter pointer to 0, rom_addr=0, playing=0 and audio_out=0.
- Reset mid-playback takes effect immediately; no sample completes.
- Trigger edge at edge T: REQ at T+1, granted at T+1 when uncontended, rom_addr valid after T+1, sample captured at T+3, audio_out updated at T+4.
- Steady state: a new sample every divider+1 clk. Worst-case grant wait is CHANNELS-1 clk.
- playing rises the edge after the trigger edge and falls on the edge where the channel enters IDLE.
- audio_out has one-clk latency from any sample register change.

## Test plan
- CH=1, DATA 8, start=0x100, length=4, divider=3, ROM 10,20,30,40, loop=0, trigger pulse: audio_out takes 2560, 5120, 7680, 10240, each held 4 clk, then 0; playing low afterwards.
- Same setup with loop=1: the sequence repeats with no gap. Clearing loop ends playback after the current pass.
- CH=2, both channels play 127, then both play -128: audio_out=32767 (clamped from 65024), then -32768.
- Stop and trigger asserted in the same cycle while playing: the channel goes IDLE and audio contribution is 0. Trigger with length=0: playing stays 0.
- Pause for 20 clk mid-sample: audio_out and rom_addr are frozen, the in-flight fetch lands, and playback resumes with no skipped sample.
- reset_n low mid-playback on a non-clock edge: all outputs are 0 immediately. After release, the channel stays IDLE until a new trigger edge.
